auth_ctrl: RTL and testbench

- Access-control sequencer that drives the user-record SYNCSRAM array through its pass/count/admin/lock ports.
- Takes a login or unlock request from the keypad/elevator front end and reads the user record.
- Checks the password, maintains the try counter and lock bit, then writes the record back and returns a grant/deny response.
- Sits between keypad decode and the SRAM wrapper; it is the only master of the SRAM.

---
 rtl/auth_pkg.sv | 28 ++
 rtl/auth_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_auth_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/auth_pkg.sv
// Shared types and defaults for the access-control sequencer.
package auth_pkg;

    localparam int unsigned DEF_ADDR_W    = 12;
    localparam int unsigned DEF_PASS_W    = 16;
    localparam int unsigned DEF_CNT_W     = 4;
    localparam int unsigned DEF_MAX_TRIES = 3;
    localparam int unsigned DEF_READ_LAT  = 1;

    // Wide enough to count down the longest supported read latency
    localparam int unsigned WAIT_W = 2;

    localparam logic OP_LOGIN  = 1'b0;
    localparam logic OP_UNLOCK = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        CHK,
        WR,
        RESP
    } state_t;

endpackage

// File: rtl/auth_ctrl.sv
// Login/unlock sequencer: reads a user record, checks the password,
// updates try counter and lock bit, writes back, and returns grant/deny.
module auth_ctrl
    import auth_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned PASS_W    = DEF_PASS_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MAX_TRIES = DEF_MAX_TRIES,
    parameter int unsigned READ_LAT  = DEF_READ_LAT
) (
    input  logic              my_clk,
    input  logic              my_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_user,
    input  logic [PASS_W-1:0] req_pass,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_grant,
    output logic              resp_admin,
    output logic              resp_locked,
    output logic              my_cs,
    output logic              my_pass_rw,
    output logic              my_admin_rw,
    output logic              my_lock_rw,
    output logic              my_count_rw,
    output logic [ADDR_W-1:0] my_addr,
    output logic [PASS_W-1:0] my_pass_in,
    output logic [CNT_W-1:0]  my_count_in,
    output logic              my_admin_in,
    output logic              my_lock_in,
    input  logic [PASS_W-1:0] my_pass_out,
    input  logic [CNT_W-1:0]  my_count_out,
    input  logic              my_admin_out,
    input  logic              my_lock_out
);

    state_t              state;
    logic                op_q;
    logic [ADDR_W-1:0]   user_q;
    logic [PASS_W-1:0]   pass_q;
    logic                admin_session;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                cs_q;
    logic [CNT_W-1:0]    cnt_sat;
    logic                lock_hit;

    // Password and admin fields are never written by this controller
    assign my_pass_rw  = RW_READ;
    assign my_admin_rw = RW_READ;
    assign my_pass_in  = '0;
    assign my_admin_in = 1'b0;

    // Reset kills a write already on the bus in the same cycle
    assign my_cs = cs_q & ~my_rst;

    // Saturating next try count and lock decision for a failed login
    always_comb begin
        cnt_sat = my_count_out;
        if (my_count_out != {CNT_W{1'b1}}) begin
            cnt_sat = my_count_out + CNT_W'(1);
        end
        lock_hit = (32'(cnt_sat) >= MAX_TRIES);
    end

    // Sequencer with registered SRAM and response outputs
    always_ff @(posedge my_clk) begin
        if (my_rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_grant    <= 1'b0;
            resp_admin    <= 1'b0;
            resp_locked   <= 1'b0;
            cs_q          <= 1'b0;
            my_count_rw   <= RW_READ;
            my_lock_rw    <= RW_READ;
            my_addr       <= '0;
            my_count_in   <= '0;
            my_lock_in    <= 1'b0;
            admin_session <= 1'b0;
            op_q          <= OP_LOGIN;
            user_q        <= '0;
            pass_q        <= '0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        user_q    <= req_user;
                        pass_q    <= req_pass;
                        req_ready <= 1'b0;
                        if (req_op == OP_LOGIN) begin
                            state   <= RD;
                            cs_q    <= 1'b1;
                            my_addr <= req_user;
                        end else if (admin_session) begin
                            state       <= WR;
                            cs_q        <= 1'b1;
                            my_addr     <= req_user;
                            my_count_rw <= RW_WRITE;
                            my_lock_rw  <= RW_WRITE;
                            my_count_in <= '0;
                            my_lock_in  <= 1'b0;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_grant <= 1'b0;
                        end
                    end
                end

                RD: begin
                    cs_q     <= 1'b0;
                    my_addr  <= '0;
                    wait_cnt <= WAIT_W'(READ_LAT - 1);
                    state    <= (READ_LAT > 1) ? WAIT : CHK;
                end

                WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) begin
                        state <= CHK;
                    end
                end

                CHK: begin
                    if (my_lock_out) begin
                        resp_locked <= 1'b1;
                        resp_valid  <= 1'b1;
                        state       <= RESP;
                    end else if (my_pass_out == pass_q) begin
                        resp_grant    <= 1'b1;
                        resp_admin    <= my_admin_out;
                        admin_session <= my_admin_out;
                        if (my_count_out != '0) begin
                            state       <= WR;
                            cs_q        <= 1'b1;
                            my_addr     <= user_q;
                            my_count_rw <= RW_WRITE;
                            my_count_in <= '0;
                        end else begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end else begin
                        admin_session <= 1'b0;
                        state         <= WR;
                        cs_q          <= 1'b1;
                        my_addr       <= user_q;
                        my_count_rw   <= RW_WRITE;
                        my_count_in   <= cnt_sat;
                        if (lock_hit) begin
                            my_lock_rw  <= RW_WRITE;
                            my_lock_in  <= 1'b1;
                            resp_locked <= 1'b1;
                        end
                    end
                end

                WR: begin
                    cs_q        <= 1'b0;
                    my_addr     <= '0;
                    my_count_rw <= RW_READ;
                    my_lock_rw  <= RW_READ;
                    my_count_in <= '0;
                    my_lock_in  <= 1'b0;
                    if (op_q == OP_UNLOCK) begin
                        resp_grant <= 1'b1;
                    end
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid  <= 1'b0;
                        resp_grant  <= 1'b0;
                        resp_admin  <= 1'b0;
                        resp_locked <= 1'b0;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_auth_ctrl.sv
// Self-checking bench for auth_ctrl with a behavioural SRAM and record model.
module tb_auth_ctrl;

    localparam int AW   = 12;
    localparam int PW   = 16;
    localparam int CW   = 4;
    localparam int MAXT = 3;

    logic          my_clk = 1'b0;
    logic          my_rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [AW-1:0] req_user;
    logic [PW-1:0] req_pass;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_grant;
    logic          resp_admin;
    logic          resp_locked;
    logic          my_cs;
    logic          my_pass_rw, my_admin_rw, my_lock_rw, my_count_rw;
    logic [AW-1:0] my_addr;
    logic [PW-1:0] my_pass_in;
    logic [CW-1:0] my_count_in;
    logic          my_admin_in;
    logic          my_lock_in;
    logic [PW-1:0] my_pass_out;
    logic [CW-1:0] my_count_out;
    logic          my_admin_out;
    logic          my_lock_out;

    // SRAM contents as seen by the DUT
    logic [PW-1:0] s_pass  [0:4095];
    logic [CW-1:0] s_count [0:4095];
    logic          s_admin [0:4095];
    logic          s_lock  [0:4095];

    // Reference record contents
    logic [PW-1:0] ref_pass  [0:4095];
    logic [CW-1:0] ref_count [0:4095];
    logic          ref_admin [0:4095];
    logic          ref_lock  [0:4095];
    logic          ref_sess;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [PW-1:0] bd_pass;
    logic [CW-1:0] bd_count;
    logic          bd_admin;
    logic          bd_lock;

    int cs_cnt = 0;
    int wr_cnt = 0;
    int lw_cnt = 0;
    int viol_cnt = 0;
    logic prev_cs = 1'b0;

    int tests = 0;
    int failed = 0;

    auth_ctrl dut (
        .my_clk       (my_clk),
        .my_rst       (my_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_user     (req_user),
        .req_pass     (req_pass),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_grant   (resp_grant),
        .resp_admin   (resp_admin),
        .resp_locked  (resp_locked),
        .my_cs        (my_cs),
        .my_pass_rw   (my_pass_rw),
        .my_admin_rw  (my_admin_rw),
        .my_lock_rw   (my_lock_rw),
        .my_count_rw  (my_count_rw),
        .my_addr      (my_addr),
        .my_pass_in   (my_pass_in),
        .my_count_in  (my_count_in),
        .my_admin_in  (my_admin_in),
        .my_lock_in   (my_lock_in),
        .my_pass_out  (my_pass_out),
        .my_count_out (my_count_out),
        .my_admin_out (my_admin_out),
        .my_lock_out  (my_lock_out)
    );

    always #5 my_clk = ~my_clk;

    // Single-cycle-latency SRAM with a backdoor preload port
    always @(posedge my_clk) begin
        if (bd_we) begin
            s_pass[bd_addr]  <= bd_pass;
            s_count[bd_addr] <= bd_count;
            s_admin[bd_addr] <= bd_admin;
            s_lock[bd_addr]  <= bd_lock;
        end else if (my_cs) begin
            if (my_pass_rw)  s_pass[my_addr]  <= my_pass_in;
            if (my_count_rw) s_count[my_addr] <= my_count_in;
            if (my_admin_rw) s_admin[my_addr] <= my_admin_in;
            if (my_lock_rw)  s_lock[my_addr]  <= my_lock_in;
            if (!my_pass_rw && !my_count_rw && !my_admin_rw && !my_lock_rw) begin
                my_pass_out  <= s_pass[my_addr];
                my_count_out <= s_count[my_addr];
                my_admin_out <= s_admin[my_addr];
                my_lock_out  <= s_lock[my_addr];
            end
        end
    end

    // Bus activity counters and protocol violations
    always @(posedge my_clk) begin
        prev_cs <= my_cs;
        if (my_cs) cs_cnt <= cs_cnt + 1;
        if (my_cs && (my_count_rw || my_lock_rw)) wr_cnt <= wr_cnt + 1;
        if (my_cs && my_lock_rw) lw_cnt <= lw_cnt + 1;
        if ((my_cs && prev_cs) || (my_cs && (my_pass_rw || my_admin_rw))) viol_cnt <= viol_cnt + 1;
    end

    task automatic preload(input logic [AW-1:0] a, input logic [PW-1:0] p,
                           input logic [CW-1:0] c, input logic adm, input logic lk);
        ref_pass[a]  = p;
        ref_count[a] = c;
        ref_admin[a] = adm;
        ref_lock[a]  = lk;
        bd_we = 1'b1; bd_addr = a; bd_pass = p; bd_count = c; bd_admin = adm; bd_lock = lk;
        @(negedge my_clk);
        bd_we = 1'b0;
    endtask

    // One complete request/response; expectations come from the record rules
    task automatic do_op(input logic op, input logic [AW-1:0] user, input logic [PW-1:0] pass,
                         input int hold, input string tag);
        logic e_grant, e_admin, e_locked;
        int e_lat, e_cs, e_wr, e_lw, lat, cs0, wr0, lw0, v0, n;
        e_grant = 1'b0; e_admin = 1'b0; e_locked = 1'b0; e_wr = 0; e_lw = 0;
        if (op == 1'b1) begin
            e_lat = 1;
            if (ref_sess) begin
                e_grant = 1'b1; e_wr = 1; e_lw = 1; e_lat = 2;
                ref_count[user] = '0;
                ref_lock[user]  = 1'b0;
            end
            e_cs = e_wr;
        end else begin
            e_lat = 3;
            if (ref_lock[user]) begin
                e_locked = 1'b1;
            end else if (ref_pass[user] == pass) begin
                e_grant  = 1'b1;
                e_admin  = ref_admin[user];
                ref_sess = ref_admin[user];
                if (ref_count[user] != '0) begin
                    ref_count[user] = '0;
                    e_wr = 1; e_lat = 4;
                end
            end else begin
                ref_sess = 1'b0;
                n = int'(ref_count[user]) + 1;
                if (n > 15) n = 15;
                ref_count[user] = CW'(n);
                if (n >= MAXT) begin
                    ref_lock[user] = 1'b1;
                    e_locked = 1'b1;
                    e_lw = 1;
                end
                e_wr = 1; e_lat = 4;
            end
            e_cs = 1 + e_wr;
        end

        cs0 = cs_cnt; wr0 = wr_cnt; lw0 = lw_cnt; v0 = viol_cnt;
        tests++;
        if (req_ready !== 1'b1) begin
            failed++; $display("FAIL %s req_ready act=%0b exp=1", tag, req_ready);
        end
        req_valid = 1'b1; req_op = op; req_user = user; req_pass = pass;
        @(negedge my_clk);
        req_valid = 1'b0; req_pass = PW'($urandom);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge my_clk);
            lat++;
        end
        tests++;
        if (lat != e_lat) begin
            failed++; $display("FAIL %s latency act=%0d exp=%0d", tag, lat, e_lat);
        end
        tests++;
        if (resp_grant !== e_grant || resp_admin !== e_admin || resp_locked !== e_locked) begin
            failed++;
            $display("FAIL %s resp g/a/l act=%0b%0b%0b exp=%0b%0b%0b", tag,
                     resp_grant, resp_admin, resp_locked, e_grant, e_admin, e_locked);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge my_clk);
            tests++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_grant !== e_grant ||
                resp_admin !== e_admin || resp_locked !== e_locked) begin
                failed++;
                $display("FAIL %s hold cyc=%0d rdy/v/g/a/l act=%0b%0b%0b%0b%0b exp=01%0b%0b%0b", tag, h,
                         req_ready, resp_valid, resp_grant, resp_admin, resp_locked,
                         e_grant, e_admin, e_locked);
            end
        end
        resp_ready = 1'b1;
        @(negedge my_clk);
        resp_ready = 1'b0;
        tests++;
        if (resp_valid !== 1'b0 || resp_grant !== 1'b0 || resp_admin !== 1'b0 || resp_locked !== 1'b0) begin
            failed++;
            $display("FAIL %s resp_clear v/g/a/l act=%0b%0b%0b%0b exp=0000", tag,
                     resp_valid, resp_grant, resp_admin, resp_locked);
        end
        tests++;
        if (cs_cnt - cs0 != e_cs || wr_cnt - wr0 != e_wr || lw_cnt - lw0 != e_lw) begin
            failed++;
            $display("FAIL %s sram cs/wr/lockwr act=%0d/%0d/%0d exp=%0d/%0d/%0d", tag,
                     cs_cnt - cs0, wr_cnt - wr0, lw_cnt - lw0, e_cs, e_wr, e_lw);
        end
        tests++;
        if (s_count[user] !== ref_count[user] || s_lock[user] !== ref_lock[user]) begin
            failed++;
            $display("FAIL %s record cnt/lock act=%0d/%0b exp=%0d/%0b", tag,
                     s_count[user], s_lock[user], ref_count[user], ref_lock[user]);
        end
        tests++;
        if (viol_cnt != v0) begin
            failed++; $display("FAIL %s bus_protocol act=%0d exp=0", tag, viol_cnt - v0);
        end
    endtask

    task automatic test_reset();
        my_rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_user = '0; req_pass = '0;
        resp_ready = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_pass = '0; bd_count = '0;
        bd_admin = 1'b0; bd_lock = 1'b0; ref_sess = 1'b0;
        repeat (3) @(negedge my_clk);
        my_rst = 1'b0;
        @(negedge my_clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failed++; $display("FAIL reset handshake act=%0b%0b exp=10", req_ready, resp_valid);
        end
        tests++;
        if (resp_grant !== 1'b0 || resp_admin !== 1'b0 || resp_locked !== 1'b0) begin
            failed++; $display("FAIL reset resp act=%0b%0b%0b exp=000", resp_grant, resp_admin, resp_locked);
        end
        tests++;
        if (my_cs !== 1'b0 || my_pass_rw !== 1'b0 || my_admin_rw !== 1'b0 ||
            my_lock_rw !== 1'b0 || my_count_rw !== 1'b0) begin
            failed++; $display("FAIL reset sram_ctl act=%0b%0b%0b%0b%0b exp=00000",
                               my_cs, my_pass_rw, my_admin_rw, my_lock_rw, my_count_rw);
        end
        tests++;
        if (my_addr !== '0 || my_pass_in !== '0 || my_count_in !== '0 ||
            my_admin_in !== 1'b0 || my_lock_in !== 1'b0) begin
            failed++; $display("FAIL reset sram_data act=%h/%h/%h/%b/%b exp=0",
                               my_addr, my_pass_in, my_count_in, my_admin_in, my_lock_in);
        end
    endtask

    task automatic test_login_ok();
        preload(12'h005, 16'h1234, 4'd0, 1'b0, 1'b0);
        do_op(1'b0, 12'h005, 16'h1234, 0, "login_ok");
    endtask

    task automatic test_lockout();
        do_op(1'b0, 12'h005, 16'h0000, 0, "bad_pass1");
        do_op(1'b0, 12'h005, 16'h0000, 1, "bad_pass2");
        do_op(1'b0, 12'h005, 16'h0000, 0, "bad_pass3_lock");
        do_op(1'b0, 12'h005, 16'h1234, 0, "locked_login");
    endtask

    task automatic test_count_clear();
        preload(12'h010, 16'hBEEF, 4'd2, 1'b0, 1'b0);
        do_op(1'b0, 12'h010, 16'hBEEF, 0, "count_clear");
    endtask

    task automatic test_unlock();
        do_op(1'b1, 12'h005, 16'h0000, 0, "unlock_denied");
        preload(12'h001, 16'hAD01, 4'd0, 1'b1, 1'b0);
        do_op(1'b0, 12'h001, 16'hAD01, 0, "admin_login");
        do_op(1'b1, 12'h005, 16'h0000, 0, "unlock_granted");
        do_op(1'b0, 12'h005, 16'h1234, 0, "login_after_unlock");
    endtask

    task automatic test_saturate();
        preload(12'h020, 16'h7777, 4'd15, 1'b0, 1'b0);
        do_op(1'b0, 12'h020, 16'h0001, 0, "saturate");
    endtask

    task automatic test_resp_hold();
        do_op(1'b0, 12'h005, 16'h1234, 5, "resp_hold");
    endtask

    task automatic test_reset_mid_wr();
        int cyc;
        int w0;
        preload(12'h030, 16'h5555, 4'd0, 1'b0, 1'b0);
        w0 = wr_cnt;
        req_valid = 1'b1; req_op = 1'b0; req_user = 12'h030; req_pass = 16'hAAAA;
        @(negedge my_clk);
        req_valid = 1'b0;
        cyc = 0;
        while (my_count_rw !== 1'b1 && cyc < 20) begin
            @(negedge my_clk);
            cyc++;
        end
        tests++;
        if (cyc >= 20) begin
            failed++; $display("FAIL rst_wr reach_wr act=timeout exp=write_cycle");
        end
        my_rst = 1'b1;
        #1;
        tests++;
        if (my_cs !== 1'b0) begin
            failed++; $display("FAIL rst_wr cs_gated act=%0b exp=0", my_cs);
        end
        @(negedge my_clk);
        my_rst = 1'b0;
        ref_sess = 1'b0;
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_grant !== 1'b0 ||
            resp_locked !== 1'b0 || my_cs !== 1'b0 || my_count_rw !== 1'b0 ||
            my_lock_rw !== 1'b0 || my_addr !== '0 || my_count_in !== '0) begin
            failed++; $display("FAIL rst_wr outputs rdy/v/g/l/cs/crw/lrw act=%0b%0b%0b%0b%0b%0b%0b exp=1000000",
                               req_ready, resp_valid, resp_grant, resp_locked, my_cs, my_count_rw, my_lock_rw);
        end
        tests++;
        if (wr_cnt != w0 || s_count[12'h030] !== 4'd0 || s_lock[12'h030] !== 1'b0) begin
            failed++; $display("FAIL rst_wr no_write writes=%0d cnt=%0d lock=%0b exp=0/0/0",
                               wr_cnt - w0, s_count[12'h030], s_lock[12'h030]);
        end
    endtask

    task automatic test_reset_clears_session();
        do_op(1'b0, 12'h001, 16'hAD01, 0, "admin_relogin");
        my_rst = 1'b1;
        @(negedge my_clk);
        my_rst = 1'b0;
        ref_sess = 1'b0;
        do_op(1'b1, 12'h020, 16'h0000, 0, "unlock_after_reset");
    endtask

    task automatic test_random();
        logic          op;
        logic [AW-1:0] u;
        logic [PW-1:0] p;
        for (int i = 0; i < 8; i++) begin
            preload(AW'(32'h100 + i), ($urandom_range(0, 1) == 1) ? 16'h1111 : 16'h2222,
                    CW'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 3) == 0);
            u  = AW'(32'h100 + $urandom_range(0, 7));
            p  = ($urandom_range(0, 1) == 1) ? 16'h1111 : 16'h2222;
            do_op(op, u, p, $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_login_ok();
        test_lockout();
        test_count_clear();
        test_unlock();
        test_saturate();
        test_resp_hold();
        test_reset_mid_wr();
        test_reset_clears_session();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
